// File: rtl/fill_pkg.sv
// Shared fill-header definitions for the trigger readout path.
// The header struct is the default-width view also used by the packet builder.
package fill_pkg;

    localparam int FILL_NUM_W = 24;
    localparam int TS_W_DEF   = 32;
    localparam int DEPTH_DEF  = 8;

    typedef struct packed {
        logic [FILL_NUM_W-1:0] fill_num;
        logic [TS_W_DEF-1:0]   timestamp;
    } fill_hdr_t;

endpackage

// File: rtl/fill_seq_checker.sv
// Sticky fill-number continuity check on accepted entries; error visible the cycle after the bad accept.
// Never stalls anything; a clear coinciding with a new mismatch leaves the flag set.
module fill_seq_checker
    import fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept,
    input  logic [FILL_NUM_W-1:0] fill_num,
    input  logic                  clr,
    output logic                  seq_err
);

    logic [FILL_NUM_W-1:0] last_num;
    logic                  first_seen;
    logic                  mismatch;

    // The first fill after reset only seeds the reference value.
    assign mismatch = accept && first_seen && (fill_num != last_num + FILL_NUM_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_num   <= '0;
            first_seen <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            if (accept) begin
                last_num   <= fill_num;
                first_seen <= 1'b1;
            end
            if (mismatch) begin
                seq_err <= 1'b1;
            end else if (clr) begin
                seq_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fill_header_fifo.sv
// Buffers fill numbers with an acceptance timestamp and presents them show-ahead, in order.
// Latency: an accept at edge N is visible at the output the cycle after N; no bypass.
// Backpressure: fill_ready is registered !full; optional FILL_SEQ_CHECK_EN adds the sequence checker.
module fill_header_fifo
    import fill_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fill_valid,
    input  logic [FILL_NUM_W-1:0]      fill_num,
    output logic                       fill_ready,
    output logic                       hdr_valid,
    output logic [FILL_NUM_W-1:0]      hdr_fill_num,
    output logic [TS_W-1:0]            hdr_timestamp,
    input  logic                       hdr_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       seq_err,
    input  logic                       clr_seq_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic [TS_W-1:0]       ts_cnt;
    logic                  rdy_q;
    logic                  wr_en;
    logic                  rd_en;

    logic [FILL_NUM_W-1:0] mem_fill [DEPTH];
    logic [TS_W-1:0]       mem_ts   [DEPTH];

    assign wr_en = fill_valid && rdy_q;
    assign rd_en = hdr_ready && (count_q != '0);

    always_comb begin
        count_nxt = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Ready comes from the next occupancy so a pop from full never passes a write through in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ts_cnt  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            ts_cnt  <= ts_cnt + TS_W'(1);
            count_q <= count_nxt;
            rdy_q   <= (count_nxt != CW'(DEPTH));
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_fill[wr_ptr] <= fill_num;
            mem_ts[wr_ptr]   <= ts_cnt;
        end
    end

    assign fill_ready    = rdy_q;
    assign count         = count_q;
    assign full          = (count_q == CW'(DEPTH));
    assign empty         = (count_q == '0);
    assign hdr_valid     = !empty;
    assign hdr_fill_num  = mem_fill[rd_ptr];
    assign hdr_timestamp = mem_ts[rd_ptr];

`ifdef FILL_SEQ_CHECK_EN
    fill_seq_checker u_seq_chk (
        .clk      (clk),
        .reset    (reset),
        .accept   (wr_en),
        .fill_num (fill_num),
        .clr      (clr_seq_err),
        .seq_err  (seq_err)
    );
`else
    logic unused_clr_seq_err;
    assign unused_clr_seq_err = clr_seq_err;
    assign seq_err            = 1'b0;
`endif

endmodule

// File: tb/tb_fill_header_fifo.sv
// Scenario bench for fill_header_fifo (DEPTH=8, TS_W=8); a negedge scoreboard checks every popped header.
module tb_fill_header_fifo;

    typedef struct {
        logic [23:0] f;
        logic [7:0]  t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fill_valid = 1'b0;
    logic [23:0] fill_num = '0;
    logic        fill_ready;
    logic        hdr_valid;
    logic [23:0] hdr_fill_num;
    logic [7:0]  hdr_timestamp;
    logic        hdr_ready = 1'b0;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        seq_err;
    logic        clr_seq_err = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pop = 0;
    logic [7:0] m_ts;
    exp_t sb_q[$];
    exp_t mon_e;

    fill_header_fifo #(.DEPTH(8), .TS_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .fill_valid    (fill_valid),
        .fill_num      (fill_num),
        .fill_ready    (fill_ready),
        .hdr_valid     (hdr_valid),
        .hdr_fill_num  (hdr_fill_num),
        .hdr_timestamp (hdr_timestamp),
        .hdr_ready     (hdr_ready),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .seq_err       (seq_err),
        .clr_seq_err   (clr_seq_err)
    );

    always #5 clk = ~clk;

    // Reference timestamp: value the counter holds during the current cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) m_ts <= 8'd0;
        else       m_ts <= m_ts + 8'd1;
    end

    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (hdr_valid && hdr_ready) begin
                n_cmp++;
                n_pop++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_pop: got fill=%h ts=%0d, nothing expected", hdr_fill_num, hdr_timestamp);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (hdr_fill_num !== mon_e.f || hdr_timestamp !== mon_e.t) begin
                        n_err++;
                        $display("FAIL sb_pop: got fill=%h ts=%0d, want fill=%h ts=%0d",
                                 hdr_fill_num, hdr_timestamp, mon_e.f, mon_e.t);
                    end
                end
            end
            if (fill_valid && fill_ready) sb_q.push_back('{f: fill_num, t: m_ts});
        end
    end

    task automatic drive_fill(input logic [23:0] v);
        bit ok = 0;
        fill_valid = 1'b1;
        fill_num   = v;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fill_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: fill %h never accepted", v);
        end
        @(posedge clk); #1;
        fill_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic wait_ts(input logic [7:0] v);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_ts == v) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL ts_wait: timestamp %0d never seen", v);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int want_pops, input string name);
        int start = n_pop;
        bit ok = 0;
        hdr_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (empty) begin ok = 1; break; end
        end
        @(posedge clk); #1 hdr_ready = 1'b0;
        n_cmp++;
        if (!ok || (n_pop - start) != want_pops || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: pops=%0d left=%0d empty_seen=%0d, want pops=%0d left=0",
                     name, n_pop - start, sb_q.size(), ok, want_pops);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({fill_ready, hdr_valid, empty, full, count, seq_err} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold: rdy=%b vld=%b empty=%b full=%b count=%0d seq_err=%b, want 0 0 1 0 0 0",
                     fill_ready, hdr_valid, empty, full, count, seq_err);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({fill_ready, hdr_valid, empty, full, count, seq_err} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b vld=%b empty=%b full=%b count=%0d seq_err=%b, want 1 0 1 0 0 0",
                     fill_ready, hdr_valid, empty, full, count, seq_err);
        end
        @(posedge clk); #1;
        drive_fill(24'd40);
        drive_fill(24'd41);
        drive_fill(24'd42);
        // Asynchronous assertion between edges.
        @(posedge clk); #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({fill_ready, hdr_valid, empty, full, count} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_async: rdy=%b vld=%b empty=%b full=%b count=%0d, want 0 0 1 0 0",
                     fill_ready, hdr_valid, empty, full, count);
        end
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_single_fill();
        hdr_ready = 1'b0;
        wait_ts(8'd99);
        fill_valid = 1'b1;
        fill_num   = 24'h000001;
        @(posedge clk); #1 fill_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({hdr_valid, hdr_fill_num, hdr_timestamp, count} !== {1'b1, 24'h000001, 8'd100, 4'd1}) begin
            n_err++;
            $display("FAIL single_out: vld=%b fill=%h ts=%0d count=%0d, want 1 000001 100 1",
                     hdr_valid, hdr_fill_num, hdr_timestamp, count);
        end
        @(posedge clk); #1 hdr_ready = 1'b1;
        @(posedge clk); #1 hdr_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({empty, hdr_valid, count} !== {1'b1, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL single_pop: empty=%b vld=%b count=%0d, want 1 0 0", empty, hdr_valid, count);
        end
    endtask

    task automatic test_fill_to_full();
        hdr_ready = 1'b0;
        for (int v = 1; v <= 8; v++) begin
            fill_valid = 1'b1;
            fill_num   = 24'(v);
            @(posedge clk); #1;
        end
        fill_num = 24'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({full, fill_ready, count, hdr_fill_num} !== {1'b1, 1'b0, 4'd8, 24'd1}) begin
            n_err++;
            $display("FAIL full_hold: full=%b rdy=%b count=%0d head=%h, want 1 0 8 000001",
                     full, fill_ready, count, hdr_fill_num);
        end
        @(posedge clk); #1 hdr_ready = 1'b1;
        @(posedge clk); #1 hdr_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({fill_ready, count} !== {1'b1, 4'd7}) begin
            n_err++;
            $display("FAIL full_pop: rdy=%b count=%0d, want 1 7", fill_ready, count);
        end
        @(posedge clk); #1 fill_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({full, count, fill_ready} !== {1'b1, 4'd8, 1'b0}) begin
            n_err++;
            $display("FAIL full_refill: full=%b count=%0d rdy=%b, want 1 8 0", full, count, fill_ready);
        end
        drain(8, "full");
    endtask

    task automatic test_back_to_back();
        logic [23:0] v = 24'd103;
        hdr_ready = 1'b0;
        drive_fill(24'd100);
        drive_fill(24'd101);
        drive_fill(24'd102);
        fill_valid = 1'b1;
        hdr_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fill_num = v;
            @(negedge clk);
            n_cmp++;
            if (count !== 4'd3 || fill_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_count[%0d]: count=%0d rdy=%b, want 3 1", i, count, fill_ready);
            end
            @(posedge clk); #1;
            v = v + 24'd1;
        end
        fill_valid = 1'b0;
        drain(3, "b2b");
    endtask

    task automatic test_ts_wrap();
        hdr_ready = 1'b0;
        wait_ts(8'd253);
        fill_valid = 1'b1; fill_num = 24'd200;
        @(posedge clk); #1 fill_valid = 1'b0;
        wait_ts(8'd1);
        fill_valid = 1'b1; fill_num = 24'd201;
        @(posedge clk); #1 fill_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({count, hdr_fill_num, hdr_timestamp} !== {4'd2, 24'd200, 8'd254}) begin
            n_err++;
            $display("FAIL wrap_first: count=%0d fill=%h ts=%0d, want 2 0000c8 254", count, hdr_fill_num, hdr_timestamp);
        end
        @(posedge clk); #1 hdr_ready = 1'b1;
        @(posedge clk); #1 hdr_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({hdr_valid, hdr_fill_num, hdr_timestamp} !== {1'b1, 24'd201, 8'd2}) begin
            n_err++;
            $display("FAIL wrap_second: vld=%b fill=%h ts=%0d, want 1 0000c9 2", hdr_valid, hdr_fill_num, hdr_timestamp);
        end
        drain(1, "wrap");
    endtask

`ifdef FILL_SEQ_CHECK_EN
    task automatic test_seq_check();
        pulse_reset();
        hdr_ready = 1'b1;
        drive_fill(24'd5);
        drive_fill(24'd6);
        @(negedge clk);
        n_cmp++;
        if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_inorder: seq_err=%b, want 0", seq_err); end
        drive_fill(24'd8);
        @(negedge clk);
        n_cmp++;
        if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_gap: seq_err=%b, want 1", seq_err); end
        @(posedge clk); #1 clr_seq_err = 1'b1;
        @(posedge clk); #1 clr_seq_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_clear: seq_err=%b, want 0", seq_err); end
        pulse_reset();
        drive_fill(24'hFFFFFF);
        drive_fill(24'h000000);
        @(negedge clk);
        n_cmp++;
        if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_wrap: seq_err=%b, want 0", seq_err); end
        clr_seq_err = 1'b1;
        drive_fill(24'd7);
        clr_seq_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_clr_vs_err: seq_err=%b, want 1", seq_err); end
        hdr_ready = 1'b0;
        pulse_reset();
    endtask
`else
    task automatic test_seq_tied();
        pulse_reset();
        hdr_ready = 1'b1;
        drive_fill(24'd5);
        drive_fill(24'd9);
        clr_seq_err = 1'b1;
        drive_fill(24'd2);
        clr_seq_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_tied: seq_err=%b, want 0", seq_err); end
        hdr_ready = 1'b0;
        pulse_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single_fill();
        test_fill_to_full();
        test_back_to_back();
        test_ts_wrap();
`ifdef FILL_SEQ_CHECK_EN
        test_seq_check();
`else
        test_seq_tied();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fill_header_fifo.md
Name: fill_header_fifo

Overview:
- Sits directly downstream of the trigger manager and consumes its fill-number valid/ready handshake.
- Buffers each completed fill's 24-bit fill number and stamps it with a free-running timestamp captured at acceptance.
- Presents buffered headers, in order, to the readout/packet builder over a show-ahead valid/ready interface.
- Decouples trigger completion from readout backpressure so the trigger path stalls only when DEPTH headers are pending.

Parameters:
- DEPTH, 8, number of header entries; power of two, 2..64.
- TS_W, 32, timestamp counter width in bits.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- fill_valid  input  1  a fill number is offered (trigger manager fifo_valid).
- fill_num  input  24  fill number offered.
- fill_ready  output  1  entry accepted this cycle when fill_valid is also high (to trigger manager fifo_ready).
- hdr_valid  output  1  a header is present at the output.
- hdr_fill_num  output  24  fill number of the oldest entry.
- hdr_timestamp  output  TS_W  timestamp of the oldest entry.
- hdr_ready  input  1  consumer takes the header this cycle.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- seq_err  output  1  sticky fill-number sequence error (optional feature).
- clr_seq_err  input  1  clears seq_err (optional feature).

Behaviour:
- Reset is asynchronous and active-high; it applies immediately, independent of clk. While asserted:
  - write pointer, read pointer, count and timestamp counter are 0;
  - fill_ready=0, hdr_valid=0, empty=1, full=0, seq_err=0;
  - the memory array is not reset.
- First cycle after reset release: fill_ready=1.
- Timestamp counter:
  - free-running; increments by 1 every cycle; wraps 2^TS_W-1 -> 0 with no flag.
- Write (accept): fill_valid & fill_ready at edge N.
  - Stores {fill_num, timestamp value during cycle N} at wr_ptr.
  - wr_ptr increments mod DEPTH.
- fill_ready = !full, registered from occupancy.
  - No same-cycle pass-through when full, even if hdr_ready=1.
  - fill_ready rises the cycle after a read from full.
- Read (pop): hdr_valid & hdr_ready at an edge; rd_ptr increments mod DEPTH.
- Outputs:
  - hdr_valid = !empty.
  - hdr_fill_num and hdr_timestamp show mem[rd_ptr] combinationally (show-ahead).
  - Their values are don't-care while hdr_valid=0 and must not be checked.
- Latency: an entry accepted at edge N into an empty buffer gives hdr_valid=1 in the cycle after edge N. There is no bypass path.
- Simultaneous write and read when 0<count<DEPTH: count unchanged; both pointers advance.
- Write when count==DEPTH is impossible by construction. Read when count==0 is ignored (hdr_valid=0).
- hdr_ready may be held high continuously. fill_valid may drop without being accepted; no protocol check is performed.
- Order is strictly first-in, first-out.
- Reset mid-operation: all pending entries are discarded; the next accepted entry appears as the first header.

Optional Feature:
- Macro: FILL_SEQ_CHECK_EN.
- Defined:
  - Holds the last accepted fill_num and a first_seen flag; both are cleared by reset.
  - The first accepted entry after reset is never an error.
  - Each later accepted entry whose fill_num is not (last+1) mod 2^24 sets seq_err the following cycle.
  - seq_err stays high until clr_seq_err=1 at an edge.
  - If clr_seq_err and a new mismatch occur at the same edge, seq_err is set (error wins).
  - A wrap 0xFFFFFF -> 0x000000 is legal.
- Not defined: seq_err is tied to 0, clr_seq_err is ignored, and no comparison logic is synthesised.

Decomposition:
- Shared package (fill_pkg):
  - FILL_NUM_W=24, default TS_W, DEPTH defaults;
  - packed header struct {fill_num, timestamp} reused by the packet builder.
- One natural sub-module: fill_seq_checker, containing last-value register, first_seen and sticky flag.
  - Instantiated only under FILL_SEQ_CHECK_EN.
- The FIFO core stays inline.

Test Plan:
- Reset and idle: assert reset for 3 cycles then release -> hdr_valid=0, empty=1, count=0, fill_ready=1, seq_err=0. Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Single fill: offer fill_num=0x000001 at timestamp 100 with hdr_ready=0 -> next cycle hdr_valid=1, hdr_fill_num=0x000001, hdr_timestamp=100, count=1. Pulse hdr_ready -> empty=1.
- Fill to full: DEPTH=8, hdr_ready=0, offer 1..9 back-to-back.
  - Expect 8 accepted, full=1, fill_ready=0, with 9 held.
  - One pop -> fill_ready=1 the next cycle, 9 accepted.
  - Drain returns 2..9 in order with increasing timestamps.
- Simultaneous write and read: at count=3, accept and pop on the same edge for 20 cycles -> count stays 3 and the output sequence is contiguous.
- Timestamp wrap: TS_W=8, accept fills at counter values 254 and 2 -> headers carry 254 then 2.
- Sequence check (FILL_SEQ_CHECK_EN):
  - Accept 5, 6, 8 -> seq_err rises one cycle after 8 is accepted.
  - Assert clr_seq_err -> seq_err falls.
  - Accept 0xFFFFFF then 0 -> no error.
  - Clear together with a new mismatch -> seq_err stays 1.
